// File: rtl/blockram_stream_reader.sv
// Streaming reader: fetches Length bytes from StartAddr out of a 1-cycle-latency block RAM.
// Latency: Start sampled at edge 0 -> first RAM read in cycle 1 -> first OutValid in cycle 3.
// Backpressure: 2-entry output FIFO; RAM reads are only issued when a slot is guaranteed.
//
// Ports
//   Clk, Reset         single clock, synchronous active-high reset
//   Start, StartAddr,  begin a transfer; address/length sampled only when idle
//   Length
//   Abort              cancel transfer, drop buffered and in-flight data, no Done
//   Busy, Done         transfer in progress / 1-cycle completion pulse
//   RamReadEnable,     RAM read port (data returns on RamReadData one cycle later)
//   RamReadAddr,
//   RamReadData
//   OutValid, OutReady, output byte stream, OutData is the FIFO head
//   OutData
module blockram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] StartAddr,
  input  logic [ADDR_WIDTH:0]   Length,
  input  logic                  Abort,
  output logic                  Busy,
  output logic                  Done,
  output logic                  RamReadEnable,
  output logic [ADDR_WIDTH-1:0] RamReadAddr,
  input  logic [DATA_WIDTH-1:0] RamReadData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutData
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_t                state;
  state_t                stateNext;

  // Transfer parameters captured at Start
  logic [ADDR_WIDTH-1:0] startAddrReg;
  logic [ADDR_WIDTH:0]   lengthReg;

  // Bytes requested from the RAM and bytes handed to the consumer
  logic [ADDR_WIDTH:0]   issuedCount;
  logic [ADDR_WIDTH:0]   acceptedCount;

  // A read was issued last cycle; its data is on RamReadData now
  logic                  readInFlight;

  // Two-entry output FIFO
  logic [DATA_WIDTH-1:0] fifoMem [2];
  logic                  fifoRdPtr;
  logic                  fifoWrPtr;
  logic [1:0]            fifoCount;

  logic                  doneReg;

  // Control decoded each cycle
  logic                  pop;
  logic                  push;
  logic                  startLoad;
  logic                  xferFinish;
  logic                  lastAccept;
  logic [2:0]            slotsUsed;

  assign OutValid    = (fifoCount != 2'd0);
  // Gated so the stale head after an abort or reset never shows on the bus
  assign OutData     = OutValid ? fifoMem[fifoRdPtr] : '0;
  assign pop         = OutValid & OutReady;
  assign push        = readInFlight;
  assign Busy        = (state == STREAM);
  assign Done        = doneReg;

  // Natural wrap at the top of the address space via truncating add
  assign RamReadAddr = startAddrReg + issuedCount[ADDR_WIDTH-1:0];

  // Slots committed after this cycle if no new read is issued: buffered bytes plus
  // the byte arriving from the RAM, minus the byte leaving this cycle.
  assign slotsUsed   = {1'b0, fifoCount} + {2'b00, readInFlight} - {2'b00, pop};

  assign lastAccept  = pop && ((acceptedCount + CNT_ONE) == lengthReg);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and control
  // ------------------------------------------------------------------
  always_comb begin
    stateNext     = state;
    RamReadEnable = 1'b0;
    startLoad     = 1'b0;
    xferFinish    = 1'b0;

    case (state)
      IDLE: begin
        if (Start) begin
          startLoad = 1'b1;
          // A zero-length request only produces the Done pulse
          if (Length != '0) begin
            stateNext = STREAM;
          end
        end
      end

      STREAM: begin
        RamReadEnable = (issuedCount < lengthReg) && (slotsUsed < 3'd2);
        if (lastAccept) begin
          xferFinish = 1'b1;
          stateNext  = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    // Abort wins over everything, including a same-cycle Start or final handshake.
    // No read is issued in the abort cycle since its data would be discarded anyway.
    if (Abort) begin
      stateNext     = IDLE;
      RamReadEnable = 1'b0;
      startLoad     = 1'b0;
      xferFinish    = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Counters, Done pulse, in-flight tracking and FIFO control
  // ------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      startAddrReg  <= '0;
      lengthReg     <= '0;
      issuedCount   <= '0;
      acceptedCount <= '0;
      readInFlight  <= 1'b0;
      doneReg       <= 1'b0;
      fifoRdPtr     <= 1'b0;
      fifoWrPtr     <= 1'b0;
      fifoCount     <= 2'd0;
    end else begin
      doneReg      <= (startLoad && (Length == '0)) || xferFinish;
      readInFlight <= RamReadEnable;

      if (startLoad) begin
        startAddrReg  <= StartAddr;
        lengthReg     <= Length;
        issuedCount   <= '0;
        acceptedCount <= '0;
      end else begin
        if (RamReadEnable) begin
          issuedCount <= issuedCount + CNT_ONE;
        end
        if (pop && !Abort) begin
          acceptedCount <= acceptedCount + CNT_ONE;
        end
      end

      if (Abort) begin
        // Buffered bytes and the read returning this cycle are dropped
        fifoRdPtr <= 1'b0;
        fifoWrPtr <= 1'b0;
        fifoCount <= 2'd0;
      end else begin
        if (push) begin
          fifoWrPtr <= ~fifoWrPtr;
        end
        if (pop) begin
          fifoRdPtr <= ~fifoRdPtr;
        end
        case ({push, pop})
          2'b10:   fifoCount <= fifoCount + 2'd1;
          2'b01:   fifoCount <= fifoCount - 2'd1;
          default: fifoCount <= fifoCount;
        endcase
      end
    end
  end

  // FIFO storage needs no reset: OutData is masked while the FIFO is empty
  always_ff @(posedge Clk) begin
    if (push && !Abort) begin
      fifoMem[fifoWrPtr] <= RamReadData;
    end
  end

endmodule

// File: tb/tb_blockram_stream_reader.sv
module tb_blockram_stream_reader;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          Clk         = 1'b0;
  logic          Reset       = 1'b1;
  logic          Start       = 1'b0;
  logic [AW-1:0] StartAddr   = '0;
  logic [AW:0]   Length      = '0;
  logic          Abort       = 1'b0;
  logic          OutReady    = 1'b0;
  logic [DW-1:0] RamReadData = '0;
  logic          Busy;
  logic          Done;
  logic          RamReadEnable;
  logic [AW-1:0] RamReadAddr;
  logic          OutValid;
  logic [DW-1:0] OutData;

  blockram_stream_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .Length       (Length),
    .Abort        (Abort),
    .Busy         (Busy),
    .Done         (Done),
    .RamReadEnable(RamReadEnable),
    .RamReadAddr  (RamReadAddr),
    .RamReadData  (RamReadData),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .OutData      (OutData)
  );

  always #5 Clk = ~Clk;

  // Block RAM with a registered read port
  logic [DW-1:0] mem [DEPTH];
  always @(posedge Clk) begin
    if (RamReadEnable) RamReadData <= mem[RamReadAddr];
  end

  int            errors = 0;
  int            checks = 0;
  int            addrQ[$];
  int            dataQ[$];
  int            issuedN   = 0;
  int            acceptedN = 0;
  int            doneCnt   = 0;
  bit            prevStall = 1'b0;
  logic [DW-1:0] prevData  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    checks++;
    if (obs !== expVal) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expVal);
    end
  endtask

  task automatic advance();
    @(posedge Clk);
    #1;
  endtask

  task automatic modelClear();
    addrQ.delete();
    dataQ.delete();
    issuedN   = 0;
    acceptedN = 0;
  endtask

  // Expected stream: addresses StartAddr+i mod depth and the bytes stored there
  task automatic modelLoad(input int addr, input int len);
    modelClear();
    for (int i = 0; i < len; i++) begin
      int a;
      a = (addr + i) % DEPTH;
      addrQ.push_back(a);
      dataQ.push_back(int'(mem[a]));
    end
  endtask

  // Mid-cycle sample: RAM reads, stream handshakes, stall stability, occupancy bound
  task automatic sample();
    @(negedge Clk);
    if (RamReadEnable) begin
      if (addrQ.size() == 0) check("ren_unexpected", RamReadEnable, 0);
      else begin
        check("ren_addr", RamReadAddr, addrQ.pop_front());
        issuedN++;
      end
    end
    if (OutValid && OutReady) begin
      if (dataQ.size() == 0) check("out_unexpected", OutValid, 0);
      else begin
        check("out_data", OutData, dataQ.pop_front());
        acceptedN++;
      end
    end
    if (RamReadEnable || (OutValid && OutReady))
      check("occupancy_over2", (issuedN - acceptedN) > 2, 0);
    if (prevStall) begin
      check("stall_valid", OutValid, 1);
      check("stall_data", OutData, prevData);
    end
    prevStall = OutValid && !OutReady && !Abort && !Reset;
    prevData  = OutData;
    if (Done) doneCnt++;
  endtask

  // mode 0: OutReady=1; mode 1: random OutReady; mode 2: OutReady low in cycles 3..7
  task automatic runXfer(input string tag, input int addr, input int len, input int mode,
                         input bit interfere);
    int doneAt;
    int budget;
    doneAt = -1;
    budget = (mode == 1) ? 4 * len + 100 : len + 100;
    modelLoad(addr, len);
    StartAddr = addr[AW-1:0];
    Length    = len[AW:0];
    Start     = 1'b1;
    OutReady  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < budget; c++) begin
      sample();
      if (mode == 0) begin
        check({tag, "_ren"},   RamReadEnable, (c >= 1) && (c <= len));
        check({tag, "_valid"}, OutValid,      (c >= 3) && (c <= len + 2));
        check({tag, "_busy"},  Busy,          (len > 0) && (c >= 1) && (c <= len + 2));
        check({tag, "_done"},  Done,          (len == 0) ? (c == 1) : (c == len + 3));
      end
      if (Done) doneAt = c;
      advance();
      Start = 1'b0;
      if (doneAt >= 0) break;
      if (interfere && c == 1) begin
        Start     = 1'b1;
        StartAddr = 10'h123;
        Length    = 11'd5;
      end
      case (mode)
        1:       OutReady = 1'($urandom_range(0, 1));
        2:       OutReady = !((c + 1 >= 3) && (c + 1 <= 7));
        default: OutReady = 1'b1;
      endcase
    end
    Start = 1'b0;
    if (mode == 0) check({tag, "_done_cycle"}, doneAt, (len == 0) ? 1 : len + 3);
    else           check({tag, "_done_seen"}, doneAt >= 0, 1);
    check({tag, "_leftover"}, addrQ.size() + dataQ.size(), 0);
    check({tag, "_busy_after"}, Busy, 0);
  endtask

  initial begin
    int a;
    int doneBefore;
    int guard;

    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);

    Reset = 1'b1;
    repeat (3) advance();
    Reset = 1'b0;
    sample();
    check("rst_busy",  Busy, 0);
    check("rst_done",  Done, 0);
    check("rst_ren",   RamReadEnable, 0);
    check("rst_addr",  RamReadAddr, 0);
    check("rst_valid", OutValid, 0);
    check("rst_data",  OutData, 0);
    advance();

    runXfer("basic",        'h010, 4,    0, 1'b0);
    runXfer("wrap",         'h3FE, 4,    0, 1'b0);
    runXfer("len0",         'h055, 0,    0, 1'b0);
    runXfer("start_busy",   'h100, 8,    0, 1'b1);
    runXfer("bp_rand",      int'($urandom_range(0, DEPTH - 1)), 8, 1, 1'b0);
    runXfer("bp_hold",      int'($urandom_range(0, DEPTH - 1)), 8, 2, 1'b0);
    runXfer("full",         'h200, 1024, 0, 1'b0);
    for (int k = 0; k < 6; k++)
      runXfer("rand", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 1, 1'b0);

    // Abort once three of ten bytes have been accepted
    a = int'($urandom_range(0, DEPTH - 1));
    modelLoad(a, 10);
    StartAddr = a[AW-1:0];
    Length    = 11'd10;
    Start     = 1'b1;
    OutReady  = 1'b1;
    guard     = 0;
    while (acceptedN < 3 && guard < 50) begin
      sample();
      advance();
      Start = 1'b0;
      guard++;
    end
    check("abort_reach", acceptedN, 3);
    doneBefore = doneCnt;
    Abort    = 1'b1;
    OutReady = 1'b0;
    sample();
    advance();
    Abort    = 1'b0;
    OutReady = 1'b1;
    modelClear();
    sample();
    check("abort_busy",  Busy, 0);
    check("abort_valid", OutValid, 0);
    check("abort_done",  Done, 0);
    repeat (4) begin
      advance();
      sample();
    end
    check("abort_no_done", doneCnt, doneBefore);
    advance();
    runXfer("after_abort", int'($urandom_range(0, DEPTH - 1)), 2, 0, 1'b0);

    // Synchronous reset in the middle of a stream
    a = int'($urandom_range(0, DEPTH - 1));
    modelLoad(a, 20);
    StartAddr = a[AW-1:0];
    Length    = 11'd20;
    Start     = 1'b1;
    OutReady  = 1'b1;
    repeat (6) begin
      sample();
      advance();
      Start = 1'b0;
    end
    Reset    = 1'b1;
    OutReady = 1'b0;
    sample();
    advance();
    Reset = 1'b0;
    modelClear();
    sample();
    check("mrst_busy",  Busy, 0);
    check("mrst_done",  Done, 0);
    check("mrst_ren",   RamReadEnable, 0);
    check("mrst_addr",  RamReadAddr, 0);
    check("mrst_valid", OutValid, 0);
    check("mrst_data",  OutData, 0);
    advance();
    runXfer("after_reset", 'h3FF, 3, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
